// File: rtl/dir_lookup.sv
// Fully-associative directory table with a one-deep registered lookup result stage.
// Optional macro DIR_LOOKUP_FWD_EN forwards same-cycle updates into the lookup result.
module dir_lookup #(
  parameter int DEPTH      = 4,
  parameter int KEY_WIDTH  = 16,
  parameter int DEST_WIDTH = 8,
  parameter int NHOP_WIDTH = 3,
  parameter int TAG_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lk_valid,
  output logic                    lk_ready,
  input  logic [KEY_WIDTH-1:0]    lk_key,
  input  logic [TAG_WIDTH-1:0]    lk_tag,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_hit,
  output logic [DEST_WIDTH-1:0]   res_dest,
  output logic [NHOP_WIDTH-1:0]   res_nhop,
  output logic [TAG_WIDTH-1:0]    res_tag,
  input  logic                    upd_valid,
  input  logic                    upd_op,
  input  logic [KEY_WIDTH-1:0]    upd_key,
  input  logic [DEST_WIDTH-1:0]   upd_dest,
  input  logic [NHOP_WIDTH-1:0]   upd_nhop,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]      ent_valid;
  logic [KEY_WIDTH-1:0]  ent_key  [DEPTH];
  logic [DEST_WIDTH-1:0] ent_dest [DEPTH];
  logic [NHOP_WIDTH-1:0] ent_nhop [DEPTH];
  logic [IDX_W-1:0]      victim;

  logic                  lk_hit;
  logic [DEST_WIDTH-1:0] lk_dest;
  logic [NHOP_WIDTH-1:0] lk_nhop;
  logic                  upd_hit;
  logic [IDX_W-1:0]      upd_idx;
  logic [IDX_W-1:0]      free_idx;
  logic                  accept;

  assign lk_ready = !res_valid || res_ready;
  assign accept   = lk_valid && lk_ready;

  // Match logic always reads the table as it stands at the start of the cycle.
  always_comb begin
    lk_hit   = 1'b0;
    lk_dest  = '0;
    lk_nhop  = '0;
    upd_hit  = 1'b0;
    upd_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_key[i] == lk_key) begin
        lk_hit  = 1'b1;
        lk_dest = ent_dest[i];
        lk_nhop = ent_nhop[i];
      end
      if (ent_valid[i] && ent_key[i] == upd_key) begin
        upd_hit = 1'b1;
        upd_idx = IDX_W'(i);
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) free_idx = IDX_W'(i);
    end
`ifdef DIR_LOOKUP_FWD_EN
    if (flush) begin
      lk_hit  = 1'b0;
      lk_dest = '0;
      lk_nhop = '0;
    end else if (upd_valid && upd_key == lk_key) begin
      lk_hit  = !upd_op;
      lk_dest = upd_op ? '0 : upd_dest;
      lk_nhop = upd_op ? '0 : upd_nhop;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      victim    <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_key[i]  <= '0;
        ent_dest[i] <= '0;
        ent_nhop[i] <= '0;
      end
    end else if (flush) begin
      ent_valid <= '0;
      occupancy <= '0;
      full      <= 1'b0;
    end else if (upd_valid) begin
      if (!upd_op) begin
        if (upd_hit) begin
          ent_dest[upd_idx] <= upd_dest;
          ent_nhop[upd_idx] <= upd_nhop;
        end else if (!full) begin
          ent_valid[free_idx] <= 1'b1;
          ent_key[free_idx]   <= upd_key;
          ent_dest[free_idx]  <= upd_dest;
          ent_nhop[free_idx]  <= upd_nhop;
          occupancy           <= occupancy + OCC_W'(1);
          full                <= (occupancy == OCC_W'(DEPTH - 1));
        end else begin
          // Round-robin replacement; the victim key cannot equal upd_key, so keys stay unique.
          ent_key[victim]  <= upd_key;
          ent_dest[victim] <= upd_dest;
          ent_nhop[victim] <= upd_nhop;
          victim           <= victim + IDX_W'(1);
        end
      end else if (upd_hit) begin
        ent_valid[upd_idx] <= 1'b0;
        occupancy          <= occupancy - OCC_W'(1);
        full               <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_dest  <= '0;
      res_nhop  <= '0;
      res_tag   <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_hit   <= lk_hit;
      res_dest  <= lk_dest;
      res_nhop  <= lk_nhop;
      res_tag   <= lk_tag;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dir_lookup.sv
// Scoreboard bench for dir_lookup: a driver feeds directed and random traffic into a
// behavioural table model, and a monitor checks every presented result against it.
module tb_dir_lookup;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid, lk_ready;
  logic [15:0] lk_key, lk_tag;
  logic        res_valid, res_ready, res_hit;
  logic [7:0]  res_dest;
  logic [2:0]  res_nhop;
  logic [15:0] res_tag;
  logic        upd_valid, upd_op;
  logic [15:0] upd_key;
  logic [7:0]  upd_dest;
  logic [2:0]  upd_nhop;
  logic        flush;
  logic [2:0]  occupancy;
  logic        full;

  dir_lookup #(.DEPTH(DEPTH), .KEY_WIDTH(16), .DEST_WIDTH(8), .NHOP_WIDTH(3), .TAG_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key), .lk_tag(lk_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_dest(res_dest), .res_nhop(res_nhop), .res_tag(res_tag),
    .upd_valid(upd_valid), .upd_op(upd_op), .upd_key(upd_key),
    .upd_dest(upd_dest), .upd_nhop(upd_nhop), .flush(flush),
    .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [7:0]  dest;
    logic [2:0]  nhop;
    logic [15:0] tag;
  } res_t;

  res_t exp_q[$];

  // Model: slots with a valid flag, plus a round-robin victim index and a result-valid flag.
  bit          mv [DEPTH];
  logic [15:0] mk [DEPTH];
  logic [7:0]  md [DEPTH];
  logic [2:0]  mn [DEPTH];
  int          mvict;
  bit          m_rv;

  bit          mon_en;
  bit          exp_rv, exp_ready, exp_full;
  int          exp_occ;
  int          tests, fails;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_valid();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += mv[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    mvict = 0;
    m_rv  = 0;
    exp_q.delete();
  endtask

  task automatic apply_stimulus(input logic lv, input logic [15:0] key, input logic [15:0] tag,
                                input logic rr, input logic uv, input logic op,
                                input logic [15:0] ukey, input logic [7:0] udest,
                                input logic [2:0] unhop, input logic fl);
    res_t e;
    int   idx;
    @(negedge clk);
    lk_valid = lv; lk_key = key; lk_tag = tag; res_ready = rr;
    upd_valid = uv; upd_op = op; upd_key = ukey; upd_dest = udest; upd_nhop = unhop; flush = fl;
    exp_rv    = m_rv;
    exp_ready = !m_rv || rr;
    exp_occ   = count_valid();
    exp_full  = (exp_occ == DEPTH);
    if (lv && exp_ready) begin
      e = '0;
      e.tag = tag;
      for (int i = 0; i < DEPTH; i++)
        if (mv[i] && mk[i] == key) begin
          e.hit = 1'b1; e.dest = md[i]; e.nhop = mn[i];
        end
`ifdef DIR_LOOKUP_FWD_EN
      if (fl) begin
        e.hit = 1'b0; e.dest = '0; e.nhop = '0;
      end else if (uv && ukey == key) begin
        e.hit  = !op;
        e.dest = op ? 8'h0 : udest;
        e.nhop = op ? 3'h0 : unhop;
      end
`endif
      exp_q.push_back(e);
      m_rv = 1;
    end else if (rr) begin
      m_rv = 0;
    end
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    end else if (uv) begin
      idx = -1;
      for (int i = 0; i < DEPTH; i++) if (mv[i] && mk[i] == ukey) idx = i;
      if (!op) begin
        if (idx < 0 && count_valid() < DEPTH) begin
          for (int i = DEPTH - 1; i >= 0; i--) if (!mv[i]) idx = i;
        end else if (idx < 0) begin
          idx   = mvict;
          mvict = (mvict + 1) % DEPTH;
        end
        mv[idx] = 1; mk[idx] = ukey; md[idx] = udest; mn[idx] = unhop;
      end else if (idx >= 0) begin
        mv[idx] = 0;
      end
    end
  endtask

  task automatic lookup(input logic [15:0] key);
    apply_stimulus(1, key, 16'($urandom), 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic insert(input logic [15:0] key, input logic [7:0] d, input logic [2:0] n);
    apply_stimulus(0, 0, 0, 1, 1, 0, key, d, n, 0);
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: runs after the driver has set this cycle's inputs, checks the presented result.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        check_output("res_valid", res_valid, exp_rv);
        check_output("lk_ready", lk_ready, exp_ready);
        check_output("occupancy", occupancy, exp_occ);
        check_output("full", full, exp_full);
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_result", 1, 0);
          end else begin
            check_output("res_hit", res_hit, exp_q[0].hit);
            check_output("res_dest", res_dest, exp_q[0].dest);
            check_output("res_nhop", res_nhop, exp_q[0].nhop);
            check_output("res_tag", res_tag, exp_q[0].tag);
            if (res_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    tests = 0; fails = 0; mon_en = 0;
    rst = 1'b0;
    lk_valid = 0; lk_key = 0; lk_tag = 0; res_ready = 0;
    upd_valid = 0; upd_op = 0; upd_key = 0; upd_dest = 0; upd_nhop = 0; flush = 0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_res_valid", res_valid, 0);
    check_output("reset_occupancy", occupancy, 0);
    check_output("reset_full", full, 0);
    check_output("reset_res_tag", res_tag, 0);
    @(negedge clk);
    rst = 1'b1; res_ready = 1;
    exp_rv = 0; exp_ready = 1; exp_occ = 0; exp_full = 0;
    mon_en = 1;

    // Miss after reset, then insert and hit.
    lookup(16'h0010);
    insert(16'h0010, 8'h21, 3'd2);
    lookup(16'h0010);
    idle();

    // Fill, replace round-robin, and wrap the victim pointer.
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) insert(16'(k), 8'(8'h40 + k), 3'(k));
    insert(16'd5, 8'h55, 3'd5);
    lookup(16'd1);
    lookup(16'd5);
    for (int k = 6; k <= 9; k++) insert(16'(k), 8'(8'h60 + k), 3'(k));
    for (int k = 1; k <= 9; k++) lookup(16'(k));
    idle();

    // Backpressure: downstream stalls with requests pending, then drains.
    for (int k = 0; k < 3; k++) apply_stimulus(1, 16'(k + 6), 16'(16'hB000 + k), 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) lookup(16'(k + 6));
    idle();

    // Same-cycle insert and lookup of key 7.
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    apply_stimulus(1, 16'd7, 16'h7777, 1, 1, 0, 16'd7, 8'h77, 3'd7, 0);
    lookup(16'd7);
    apply_stimulus(1, 16'd7, 16'h7778, 1, 1, 1, 16'd7, 0, 0, 0);
    lookup(16'd7);

    // Flush wins over a simultaneous insert.
    insert(16'hA1, 8'h11, 3'd1);
    insert(16'hA2, 8'h12, 3'd2);
    insert(16'hA3, 8'h13, 3'd3);
    apply_stimulus(1, 16'hA1, 16'hF1F1, 1, 1, 0, 16'hA4, 8'h14, 3'd4, 1);
    lookup(16'hA2);
    lookup(16'hA4);
    idle();
    check_output("flush_occupancy", occupancy, 0);

    // Asynchronous reset in the middle of a stall.
    insert(16'h33, 8'h33, 3'd3);
    lookup(16'h33);
    apply_stimulus(1, 16'h34, 16'h3434, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    mon_en = 0;
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_res_valid", res_valid, 0);
    check_output("async_rst_lk_ready", lk_ready, 1);
    check_output("async_rst_occupancy", occupancy, 0);
    check_output("async_rst_res_hit", res_hit, 0);
    lk_valid = 0; upd_valid = 0; flush = 0; res_ready = 1;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    exp_rv = 0; exp_ready = 1; exp_occ = 0; exp_full = 0;
    mon_en = 1;
    lookup(16'h33);
    idle();

    // Randomized traffic over a small key space to exercise hits, replacement and invalidates.
    for (int n = 0; n < 2000; n++) begin
      apply_stimulus($urandom_range(0, 9) < 7, 16'($urandom_range(0, 7)), 16'($urandom),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                     $urandom_range(0, 9) < 3, 16'($urandom_range(0, 7)),
                     8'($urandom), 3'($urandom), $urandom_range(0, 99) < 3);
    end
    repeat (3) idle();
    check_output("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
